// File: rtl/backend_pkg.sv
// Shared types and length arithmetic for the packet backend transmitter.
package backend_pkg;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      STREAM = 2'd1,
      DONE   = 2'd2
   } tx_state_t;

   localparam int BEAT_BYTES = 32;
   localparam int MAX_LEN    = 2048;

   // Byte enables of the final beat: a zero residue means the beat is full.
   function automatic logic [31:0] keep_from_residue(input logic [4:0] r);
      logic [31:0] k;
      if (r == 5'd0) begin
         k = 32'hFFFF_FFFF;
      end else begin
         k = (32'd1 << r) - 32'd1;
      end
      return k;
   endfunction

   // Beat count of a packet, clamped to the 2048-byte maximum and the BRAM depth.
   function automatic logic [6:0] beats_from_len(input logic [15:0] len, input int max_beats);
      logic [16:0] b;
      b = ({1'b0, len} + 17'(BEAT_BYTES - 1)) >> 5;
      if (b > 17'(MAX_LEN / BEAT_BYTES)) begin
         b = 17'(MAX_LEN / BEAT_BYTES);
      end
      if (b > 17'(max_beats)) begin
         b = 17'(max_beats);
      end
      return 7'(b);
   endfunction

endpackage

// File: rtl/backend_tx_if.sv
// AXI4-Stream beat bus between the backend transmitter and its downstream sink.
interface backend_tx_if;
   logic [255:0] tdata;
   logic [31:0]  tkeep;
   logic         tvalid;
   logic         tlast;
   logic         tready;

   modport master (
      output tdata,
      output tkeep,
      output tvalid,
      output tlast,
      input  tready
   );

   modport slave (
      input  tdata,
      input  tkeep,
      input  tvalid,
      input  tlast,
      output tready
   );
endinterface

// File: rtl/tx_beat_fifo.sv
// Small first-word-fall-through beat buffer; the head entry is visible
// combinationally so it can drive the stream outputs without a bubble.
module tx_beat_fifo #(
   parameter int DEPTH = 4,
   parameter int WIDTH = 257,
   parameter int CW    = $clog2(DEPTH) + 1
) (
   input  logic             aclk,
   input  logic             aresetn,
   input  logic             push,
   input  logic [WIDTH-1:0] push_data,
   input  logic             pop,
   output logic [WIDTH-1:0] head_data,
   output logic             empty,
   output logic [CW-1:0]    count
);
   localparam int AW = $clog2(DEPTH);

   logic [WIDTH-1:0] mem_reg [DEPTH];
   logic [AW-1:0]    wr_ptr_reg;
   logic [AW-1:0]    rd_ptr_reg;
   logic [CW-1:0]    count_reg;
   logic             do_push;
   logic             do_pop;

   assign do_pop  = pop && (count_reg != '0);
   assign do_push = push && (count_reg != CW'(DEPTH));

   // Storage: written on push, contents need no reset because empty gates the head.
   always_ff @(posedge aclk) begin
      if (do_push) begin
         mem_reg[wr_ptr_reg] <= push_data;
      end
   end

   // Pointers and occupancy.
   always_ff @(posedge aclk or negedge aresetn) begin
      if (!aresetn) begin
         wr_ptr_reg <= '0;
         rd_ptr_reg <= '0;
         count_reg  <= '0;
      end else begin
         if (do_push) begin
            wr_ptr_reg <= wr_ptr_reg + AW'(1);
         end
         if (do_pop) begin
            rd_ptr_reg <= rd_ptr_reg + AW'(1);
         end
         case ({do_push, do_pop})
            2'b10:   count_reg <= count_reg + CW'(1);
            2'b01:   count_reg <= count_reg - CW'(1);
            default: count_reg <= count_reg;
         endcase
      end
   end

   assign head_data = mem_reg[rd_ptr_reg];
   assign empty     = (count_reg == '0);
   assign count     = count_reg;
endmodule

// File: rtl/backend_tx.sv
// Backend transmitter: reads a packet out of the shared BRAM (port B) and
// streams it on AXI4-Stream, pulsing finish after the last beat is accepted.
module backend_tx
   import backend_pkg::*;
#(
   parameter int RD_LAT     = 1,
   parameter int FIFO_DEPTH = 4,
   parameter int MAX_BEATS  = 64
) (
   input  logic         aclk,
   input  logic         aresetn,
   input  logic         start,
   input  logic [15:0]  length_be,
   output logic         finish,
   output logic         bram_enb,
   output logic [5:0]   bram_addrb,
   input  logic [255:0] bram_doutb,
   backend_tx_if.master m_axis
);
   localparam int CW = $clog2(FIFO_DEPTH) + 1;

   tx_state_t         state_reg;
   tx_state_t         state_next;
   logic [6:0]        beats_reg;
   logic [6:0]        issued_reg;
   logic [31:0]       keep_last_reg;
   logic [RD_LAT-1:0] pipe_vld_reg;
   logic [RD_LAT-1:0] pipe_last_reg;
   logic [CW-1:0]     fifo_count;
   logic [CW-1:0]     inflight;
   logic [CW:0]       committed;
   logic              has_credit;
   logic              issue;
   logic              issue_last;
   logic              start_pkt;
   logic              fifo_empty;
   logic              pop;
   logic              head_last;
   logic [256:0]      head_data;
   logic [4:0]        residue;

   assign start_pkt = (state_reg == IDLE) && start && (length_be != 16'd0);
   // Oversized packets are clamped to 2048 bytes, whose last beat is full.
   assign residue   = (length_be > 16'(MAX_LEN)) ? 5'd0 : length_be[4:0];

   // Reads are only issued while the FIFO can absorb every beat already requested.
   always_comb begin
      inflight = '0;
      for (int i = 0; i < RD_LAT; i++) begin
         inflight = inflight + CW'(pipe_vld_reg[i]);
      end
   end

   assign committed  = {1'b0, fifo_count} + {1'b0, inflight};
   assign has_credit = committed < (CW+1)'(FIFO_DEPTH);
   assign issue      = (state_reg == STREAM) && (issued_reg < beats_reg) && has_credit;
   assign issue_last = (issued_reg == beats_reg - 7'd1);
   assign bram_enb   = issue;
   assign bram_addrb = issued_reg[5:0];

   // Per-packet configuration and read pointer.
   always_ff @(posedge aclk or negedge aresetn) begin
      if (!aresetn) begin
         beats_reg     <= '0;
         keep_last_reg <= '0;
         issued_reg    <= '0;
      end else if (start_pkt) begin
         beats_reg     <= beats_from_len(length_be, MAX_BEATS);
         keep_last_reg <= keep_from_residue(residue);
         issued_reg    <= '0;
      end else if (issue) begin
         issued_reg    <= issued_reg + 7'd1;
      end
   end

   // Read-latency tracker: marks when BRAM data lands and whether it is the last beat.
   always_ff @(posedge aclk or negedge aresetn) begin
      if (!aresetn) begin
         pipe_vld_reg  <= '0;
         pipe_last_reg <= '0;
      end else begin
         pipe_vld_reg[0]  <= issue;
         pipe_last_reg[0] <= issue && issue_last;
         for (int i = 1; i < RD_LAT; i++) begin
            pipe_vld_reg[i]  <= pipe_vld_reg[i-1];
            pipe_last_reg[i] <= pipe_last_reg[i-1];
         end
      end
   end

   tx_beat_fifo #(
      .DEPTH (FIFO_DEPTH),
      .WIDTH (257),
      .CW    (CW)
   ) u_fifo (
      .aclk      (aclk),
      .aresetn   (aresetn),
      .push      (pipe_vld_reg[RD_LAT-1]),
      .push_data ({pipe_last_reg[RD_LAT-1], bram_doutb}),
      .pop       (pop),
      .head_data (head_data),
      .empty     (fifo_empty),
      .count     (fifo_count)
   );

   // The FIFO head is the stream beat; it stays put until accepted.
   assign head_last     = head_data[256];
   assign pop           = !fifo_empty && m_axis.tready;
   assign m_axis.tvalid = !fifo_empty;
   assign m_axis.tdata  = fifo_empty ? 256'd0 : head_data[255:0];
   assign m_axis.tlast  = !fifo_empty && head_last;
   assign m_axis.tkeep  = fifo_empty ? 32'd0 : (head_last ? keep_last_reg : 32'hFFFF_FFFF);

   // State register.
   always_ff @(posedge aclk or negedge aresetn) begin
      if (!aresetn) begin
         state_reg <= IDLE;
      end else begin
         state_reg <= state_next;
      end
   end

   // Next-state and finish decode; start is only honoured in IDLE.
   always_comb begin
      state_next = state_reg;
      finish     = 1'b0;
      case (state_reg)
         IDLE: begin
            if (start) begin
               state_next = (length_be != 16'd0) ? STREAM : DONE;
            end
         end
         STREAM: begin
            if (pop && head_last) begin
               state_next = DONE;
            end
         end
         DONE: begin
            finish     = 1'b1;
            state_next = IDLE;
         end
         default: state_next = IDLE;
      endcase
   end
endmodule

// File: tb/tb_backend_tx.sv
// Directed bench for backend_tx with a behavioural port-B BRAM.
module tb_backend_tx;
   localparam int RD_LAT = 1;

   logic         aclk       = 1'b0;
   logic         aresetn    = 1'b0;
   logic         start      = 1'b0;
   logic [15:0]  length_be  = 16'd0;
   logic         finish;
   logic         bram_enb;
   logic [5:0]   bram_addrb;
   logic [255:0] bram_doutb = '0;

   int checks = 0;
   int errors = 0;

   backend_tx_if axis_if ();

   backend_tx #(
      .RD_LAT     (RD_LAT),
      .FIFO_DEPTH (4),
      .MAX_BEATS  (64)
   ) dut (
      .aclk       (aclk),
      .aresetn    (aresetn),
      .start      (start),
      .length_be  (length_be),
      .finish     (finish),
      .bram_enb   (bram_enb),
      .bram_addrb (bram_addrb),
      .bram_doutb (bram_doutb),
      .m_axis     (axis_if)
   );

   always #5 aclk = ~aclk;

   // Distinct contents per address and lane so ordering errors show up.
   function automatic logic [255:0] bram_word(input int a);
      logic [255:0] w;
      for (int i = 0; i < 8; i++) begin
         w[i*32 +: 32] = {8'(a), 8'(i), 16'(a * 97 + i * 13 + 1)};
      end
      return w;
   endfunction

   always @(posedge aclk) begin
      if (bram_enb) begin
         bram_doutb <= bram_word(int'(bram_addrb));
      end
   end

   task automatic check(input string tag, input logic [255:0] obs, input logic [255:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic run_packet(input string tag, input logic [15:0] len, input int exp_beats,
                             input logic [31:0] exp_keep_last, input bit rand_ready,
                             input int restart_at);
      int          idx         = 0;
      int          reads       = 0;
      int          first_valid = -1;
      int          first_hs    = -1;
      int          last_hs     = -1;
      int          fin_cnt     = 0;
      int          fin_k       = -1;
      bit          stalled     = 1'b0;
      logic [255:0] held_data  = '0;
      logic [31:0]  held_keep  = '0;
      logic         held_last  = 1'b0;
      logic [31:0]  exp_keep;
      start          = 1'b1;
      length_be      = len;
      axis_if.tready = 1'b1;
      @(negedge aclk);
      start = 1'b0;
      for (int k = 0; k < 400; k++) begin
         if (k == restart_at) begin
            start     = 1'b1;
            length_be = 16'd64;
         end else begin
            start = 1'b0;
         end
         if (bram_enb) begin
            check({tag, "_addr"}, 256'(bram_addrb), 256'(reads));
            reads++;
         end
         if (stalled) begin
            check({tag, "_stall_valid"}, 256'(axis_if.tvalid), 256'(1));
            check({tag, "_stall_data"}, axis_if.tdata, held_data);
            check({tag, "_stall_keep"}, 256'(axis_if.tkeep), 256'(held_keep));
            check({tag, "_stall_last"}, 256'(axis_if.tlast), 256'(held_last));
         end
         if (axis_if.tvalid) begin
            if (first_valid < 0) first_valid = k;
            check({tag, "_beat_in_range"}, 256'(idx < exp_beats), 256'(1));
            exp_keep = (idx == exp_beats - 1) ? exp_keep_last : 32'hFFFF_FFFF;
            check({tag, "_data"}, axis_if.tdata, bram_word(idx));
            check({tag, "_keep"}, 256'(axis_if.tkeep), 256'(exp_keep));
            check({tag, "_last"}, 256'(axis_if.tlast), 256'(idx == exp_beats - 1));
         end
         if (finish) begin
            fin_cnt++;
            fin_k = k;
         end
         axis_if.tready = rand_ready ? 1'($urandom_range(0, 1)) : 1'b1;
         if (axis_if.tvalid && axis_if.tready) begin
            if (first_hs < 0) first_hs = k;
            last_hs = k;
            idx++;
         end
         stalled   = axis_if.tvalid && !axis_if.tready;
         held_data = axis_if.tdata;
         held_keep = axis_if.tkeep;
         held_last = axis_if.tlast;
         if (idx >= exp_beats && fin_cnt > 0 && k >= fin_k + 2) break;
         @(negedge aclk);
      end
      start = 1'b0;
      $display("packet %s len=%0d beats=%0d reads=%0d finish_pulses=%0d", tag, len, idx, reads, fin_cnt);
      check({tag, "_beats"}, 256'(idx), 256'(exp_beats));
      check({tag, "_reads"}, 256'(reads), 256'(exp_beats));
      check({tag, "_finish_count"}, 256'(fin_cnt), 256'(1));
      check({tag, "_finish_cycle"}, 256'(fin_k), 256'((exp_beats == 0) ? 0 : last_hs + 1));
      if (exp_beats > 0) begin
         check({tag, "_first_valid_latency"},
               256'(first_valid >= 0 && first_valid <= RD_LAT + 2), 256'(1));
      end else begin
         check({tag, "_no_valid"}, 256'(first_valid), 256'(-1));
      end
      if (exp_beats > 0 && !rand_ready) begin
         check({tag, "_no_bubbles"}, 256'(last_hs - first_hs), 256'(exp_beats - 1));
      end
   endtask

   initial begin
      axis_if.tready = 1'b0;
      aresetn        = 1'b0;
      repeat (3) @(negedge aclk);
      check("rst_finish", 256'(finish), 256'(0));
      check("rst_enb", 256'(bram_enb), 256'(0));
      check("rst_addr", 256'(bram_addrb), 256'(0));
      check("rst_tvalid", 256'(axis_if.tvalid), 256'(0));
      check("rst_tlast", 256'(axis_if.tlast), 256'(0));
      check("rst_tkeep", 256'(axis_if.tkeep), 256'(0));
      check("rst_tdata", axis_if.tdata, 256'(0));
      aresetn = 1'b1;
      @(negedge aclk);

      run_packet("p60", 16'd60, 2, 32'h0FFF_FFFF, 1'b0, -1);
      run_packet("p1514", 16'd1514, 48, 32'h0000_03FF, 1'b0, 10);
      run_packet("p64", 16'd64, 2, 32'hFFFF_FFFF, 1'b0, -1);
      run_packet("p256r", 16'd256, 8, 32'hFFFF_FFFF, 1'b1, -1);
      run_packet("p0", 16'd0, 0, 32'hFFFF_FFFF, 1'b0, -1);

      // Reset in the middle of a packet.
      start          = 1'b1;
      length_be      = 16'd256;
      axis_if.tready = 1'b1;
      @(negedge aclk);
      start = 1'b0;
      repeat (4) @(negedge aclk);
      check("rstmid_active", 256'(axis_if.tvalid), 256'(1));
      aresetn = 1'b0;
      #1;
      check("rstmid_tvalid", 256'(axis_if.tvalid), 256'(0));
      check("rstmid_tlast", 256'(axis_if.tlast), 256'(0));
      check("rstmid_tkeep", 256'(axis_if.tkeep), 256'(0));
      check("rstmid_tdata", axis_if.tdata, 256'(0));
      check("rstmid_enb", 256'(bram_enb), 256'(0));
      check("rstmid_finish", 256'(finish), 256'(0));
      for (int i = 0; i < 6; i++) begin
         @(negedge aclk);
         if (i == 2) aresetn = 1'b1;
         check("rstmid_no_finish", 256'(finish), 256'(0));
         check("rstmid_idle_valid", 256'(axis_if.tvalid), 256'(0));
      end
      $display("reset mid-packet applied and released");

      run_packet("p60_after_rst", 16'd60, 2, 32'h0FFF_FFFF, 1'b0, -1);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
